// File: rtl/collision_unit.sv
// collision_unit: bounce-pulse generator, 4x4 brick map, score and ball-lost
// detection for the brick-breaker datapath.
// Optional feature macro: SCORE_EN (when undefined, score is tied to zero and
// no score flops are built).
module collision_unit #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int PADDLE_Y    = 110,
  parameter int PADDLE_W    = 16,
  parameter int BRICK_TOP   = 8,
  parameter int BRICK_W     = 40,
  parameter int BRICK_H     = 8,
  parameter int HOLD_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic [7:0]  ballX,
  input  logic [7:0]  ballY,
  input  logic [2:0]  vX,
  input  logic [2:0]  vY,
  input  logic [7:0]  paddleX,
  output logic        cX,
  output logic        cY,
  output logic [15:0] brickMap,
  output logic [7:0]  score,
  output logic        lost,
  output logic        cleared
);

  // Geometry constants widened to 9 bits so ball+1 and paddle+width never wrap.
  localparam logic [8:0] RIGHT_X    = 9'(SCREEN_W - 1);
  localparam logic [8:0] BOTTOM_Y   = 9'(SCREEN_H - 1);
  localparam logic [8:0] PADDLE_ROW = 9'(PADDLE_Y);
  localparam logic [8:0] PADDLE_EXT = 9'(PADDLE_W - 1);
  localparam logic [8:0] ROW0_Y     = 9'(BRICK_TOP);
  localparam logic [8:0] ROW1_Y     = 9'(BRICK_TOP + BRICK_H);
  localparam logic [8:0] ROW2_Y     = 9'(BRICK_TOP + 2 * BRICK_H);
  localparam logic [8:0] ROW3_Y     = 9'(BRICK_TOP + 3 * BRICK_H);
  localparam logic [8:0] FIELD_YEND = 9'(BRICK_TOP + 4 * BRICK_H - 1);
  localparam logic [8:0] COL1_X     = 9'(BRICK_W);
  localparam logic [8:0] COL2_X     = 9'(2 * BRICK_W);
  localparam logic [8:0] COL3_X     = 9'(3 * BRICK_W);
  localparam logic [8:0] FIELD_XEND = 9'(4 * BRICK_W);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES);

  localparam logic [2:0] ST_SERVE = 3'b000;
  localparam logic [2:0] ST_PLAY  = 3'b001;

  logic [15:0] map_reg, map_next;
  logic [3:0]  hold_x_reg, hold_x_next;
  logic [3:0]  hold_y_reg, hold_y_next;
  logic        lost_seen_reg, lost_seen_next;
  logic        cx_reg, cx_next;
  logic        cy_reg, cy_next;
  logic        lost_reg, lost_next;

  logic [8:0] bx, by, px, paddle_right;
  logic       in_play, in_serve;
  logic       wall_right, wall_left, wall_top, paddle_hit, bottom_hit;
  logic       brick_zone, brick_live, brick_clear;
  logic [1:0] brick_row, brick_col;
  logic [3:0] brick_idx;
  logic       x_event, y_event, lost_event;

  assign bx           = {1'b0, ballX};
  assign by           = {1'b0, ballY};
  assign px           = {1'b0, paddleX};
  assign paddle_right = px + PADDLE_EXT;
  assign in_play      = (state == ST_PLAY);
  assign in_serve     = (state == ST_SERVE);

  // Collision detectors and brick addressing via comparison chains.
  always_comb begin
    wall_right = !vX[2] && (bx >= RIGHT_X);
    wall_left  =  vX[2] && (bx == 9'd0);
    wall_top   =  vY[2] && (by == 9'd0);
    paddle_hit = !vY[2] && ((by + 9'd1) == PADDLE_ROW) &&
                 (bx >= px) && (bx <= paddle_right);
    bottom_hit = !vY[2] && (by >= BOTTOM_Y);
    brick_zone = (by >= ROW0_Y) && (by <= FIELD_YEND) && (bx < FIELD_XEND);

    if (by >= ROW3_Y)      brick_row = 2'd3;
    else if (by >= ROW2_Y) brick_row = 2'd2;
    else if (by >= ROW1_Y) brick_row = 2'd1;
    else                   brick_row = 2'd0;

    if (bx >= COL3_X)      brick_col = 2'd3;
    else if (bx >= COL2_X) brick_col = 2'd2;
    else if (bx >= COL1_X) brick_col = 2'd1;
    else                   brick_col = 2'd0;

    brick_idx  = {brick_row, brick_col};
    brick_live = brick_zone && map_reg[brick_idx];

    // A brick hit while the Y axis is held off is ignored entirely.
    brick_clear = in_play && (hold_y_reg == 4'd0) && brick_live;
    x_event     = in_play && (hold_x_reg == 4'd0) && (wall_right || wall_left);
    y_event     = in_play && (hold_y_reg == 4'd0) &&
                  (wall_top || paddle_hit || brick_live);
    lost_event  = in_play && bottom_hit && !lost_seen_reg;
  end

  // Next-state for map, hold counters, lost latch and the output pulses.
  always_comb begin
    map_next       = map_reg;
    hold_x_next    = hold_x_reg;
    hold_y_next    = hold_y_reg;
    lost_seen_next = lost_seen_reg;
    cx_next        = 1'b0;
    cy_next        = 1'b0;
    lost_next      = 1'b0;

    if (in_serve) begin
      map_next       = 16'hFFFF;
      hold_x_next    = 4'd0;
      hold_y_next    = 4'd0;
      lost_seen_next = 1'b0;
    end else if (in_play) begin
      if (x_event) begin
        cx_next     = 1'b1;
        hold_x_next = HOLD_LOAD;
      end else if (hold_x_reg != 4'd0) begin
        hold_x_next = hold_x_reg - 4'd1;
      end

      if (y_event) begin
        cy_next     = 1'b1;
        hold_y_next = HOLD_LOAD;
      end else if (hold_y_reg != 4'd0) begin
        hold_y_next = hold_y_reg - 4'd1;
      end

      if (brick_clear)
        map_next = map_reg & ~(16'h0001 << brick_idx);

      if (lost_event) begin
        lost_next      = 1'b1;
        lost_seen_next = 1'b1;
      end
    end
  end

  // State and output registers; reset clears pulses immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      map_reg       <= 16'hFFFF;
      hold_x_reg    <= 4'd0;
      hold_y_reg    <= 4'd0;
      lost_seen_reg <= 1'b0;
      cx_reg        <= 1'b0;
      cy_reg        <= 1'b0;
      lost_reg      <= 1'b0;
    end else begin
      map_reg       <= map_next;
      hold_x_reg    <= hold_x_next;
      hold_y_reg    <= hold_y_next;
      lost_seen_reg <= lost_seen_next;
      cx_reg        <= cx_next;
      cy_reg        <= cy_next;
      lost_reg      <= lost_next;
    end
  end

`ifdef SCORE_EN
  logic [7:0] score_reg, score_next;

  // Score counts cleared bricks, saturating at 255, and restarts on serve.
  always_comb begin
    score_next = score_reg;
    if (in_serve)
      score_next = 8'd0;
    else if (brick_clear && (score_reg != 8'hFF))
      score_next = score_reg + 8'd1;
  end

  // Score register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) score_reg <= 8'd0;
    else        score_reg <= score_next;
  end

  assign score = score_reg;
`else
  assign score = 8'd0;
`endif

  assign cX       = cx_reg;
  assign cY       = cy_reg;
  assign lost     = lost_reg;
  assign brickMap = map_reg;
  assign cleared  = (map_reg == 16'h0000);

endmodule

// File: tb/tb_collision_unit.sv
// Scoreboard bench for collision_unit: stimulus pushes the expected registered
// response for each clock; a negedge monitor pops and compares.
module tb_collision_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic [7:0]  ballX, ballY, paddleX;
  logic [2:0]  vX, vY;
  logic        cX, cY, lost, cleared;
  logic [15:0] brickMap;
  logic [7:0]  score;

  always #5 clock = ~clock;

  collision_unit dut (
    .clock    (clock),
    .reset    (reset),
    .state    (state),
    .ballX    (ballX),
    .ballY    (ballY),
    .vX       (vX),
    .vY       (vY),
    .paddleX  (paddleX),
    .cX       (cX),
    .cY       (cY),
    .brickMap (brickMap),
    .score    (score),
    .lost     (lost),
    .cleared  (cleared)
  );

  typedef struct packed {
    logic        cx;
    logic        cy;
    logic        lost;
    logic [15:0] map;
    logic [7:0]  score;
    logic        cleared;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    checks = 0;
  int    passed = 0;

  function automatic logic [7:0] exp_score(input logic [7:0] s);
`ifdef SCORE_EN
    return s;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string name, input string field, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
  endtask

  // Monitor: one registered response per clock, compared at the falling edge.
  always @(negedge clock) begin
    if (sb.size() != 0) begin
      exp_t  e;
      string n;
      e = sb.pop_front();
      n = tq.pop_front();
      chk(n, "cX",       int'(cX),       int'(e.cx));
      chk(n, "cY",       int'(cY),       int'(e.cy));
      chk(n, "lost",     int'(lost),     int'(e.lost));
      chk(n, "brickMap", int'(brickMap), int'(e.map));
      chk(n, "score",    int'(score),    int'(e.score));
      chk(n, "cleared",  int'(cleared),  int'(e.cleared));
      $display("txn %-10s cX=%b cY=%b lost=%b map=%h score=%0d cleared=%b",
               n, cX, cY, lost, brickMap, score, cleared);
    end
  end

  task automatic step(input string name, input logic cx, input logic cy, input logic lo,
                      input logic [15:0] map, input logic [7:0] sc);
    exp_t e;
    @(posedge clock);
    e.cx      = cx;
    e.cy      = cy;
    e.lost    = lo;
    e.map     = map;
    e.score   = exp_score(sc);
    e.cleared = (map == 16'h0000);
    sb.push_back(e);
    tq.push_back(name);
    @(negedge clock);
  endtask

  task automatic drive(input logic [2:0] st, input logic [7:0] x, input logic [7:0] y,
                       input logic [2:0] vx, input logic [2:0] vy);
    state = st;
    ballX = x;
    ballY = y;
    vX    = vx;
    vY    = vy;
  endtask

  initial begin
    logic [15:0] m;
    reset   = 1'b0;
    paddleX = 8'd0;
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);

    // Reset and serve
    step("reset", 0, 0, 0, 16'hFFFF, 0);
    step("reset", 0, 0, 0, 16'hFFFF, 0);
    reset = 1'b1;
    step("serve", 0, 0, 0, 16'hFFFF, 0);

    // Right wall held for 5 clocks: pulse, 3 held off, pulse again
    drive(3'b001, 8'd159, 8'd60, 3'b001, 3'b001);
    step("rwall", 1, 0, 0, 16'hFFFF, 0);
    step("rwall", 0, 0, 0, 16'hFFFF, 0);
    step("rwall", 0, 0, 0, 16'hFFFF, 0);
    step("rwall", 0, 0, 0, 16'hFFFF, 0);
    step("rwall", 1, 0, 0, 16'hFFFF, 0);
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);
    step("serve", 0, 0, 0, 16'hFFFF, 0);

    // Top-left corner: both axes in the same clock
    drive(3'b001, 8'd0, 8'd0, 3'b101, 3'b101);
    step("corner", 1, 1, 0, 16'hFFFF, 0);
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);
    step("serve", 0, 0, 0, 16'hFFFF, 0);

    // Brick row 1 col 1 (bit 5); second brick inside holdY is ignored
    drive(3'b001, 8'd50, 8'd20, 3'b001, 3'b101);
    step("brick", 0, 1, 0, 16'hFFDF, 1);
    drive(3'b001, 8'd90, 8'd20, 3'b001, 3'b101);
    step("brk_hold", 0, 0, 0, 16'hFFDF, 1);
    drive(3'b001, 8'd50, 8'd20, 3'b001, 3'b101);
    step("brk_hold", 0, 0, 0, 16'hFFDF, 1);
    step("brk_hold", 0, 0, 0, 16'hFFDF, 1);
    step("brk_dead", 0, 0, 0, 16'hFFDF, 1);

    // Freeze: registers hold and pulses are forced low even at a wall
    drive(3'b010, 8'd159, 8'd20, 3'b001, 3'b101);
    step("freeze", 0, 0, 0, 16'hFFDF, 1);
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);
    step("serve", 0, 0, 0, 16'hFFFF, 0);

    // Paddle at x=40..55
    paddleX = 8'd40;
    drive(3'b001, 8'd55, 8'd109, 3'b001, 3'b001);
    step("paddle55", 0, 1, 0, 16'hFFFF, 0);
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);
    step("serve", 0, 0, 0, 16'hFFFF, 0);
    drive(3'b001, 8'd56, 8'd109, 3'b001, 3'b001);
    step("paddle56", 0, 0, 0, 16'hFFFF, 0);

    // Ball lost: single pulse while held, re-armed by serve
    drive(3'b001, 8'd80, 8'd119, 3'b001, 3'b001);
    step("lost", 0, 0, 1, 16'hFFFF, 0);
    step("lost_hold", 0, 0, 0, 16'hFFFF, 0);
    step("lost_hold", 0, 0, 0, 16'hFFFF, 0);
    drive(3'b000, 8'd80, 8'd119, 3'b001, 3'b001);
    step("serve", 0, 0, 0, 16'hFFFF, 0);
    drive(3'b001, 8'd80, 8'd119, 3'b001, 3'b001);
    step("lost_rearm", 0, 0, 1, 16'hFFFF, 0);
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);
    step("serve", 0, 0, 0, 16'hFFFF, 0);

    // Clear every brick, waiting out holdY between hits
    m = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      drive(3'b001, 8'(20 + 40 * (i % 4)), 8'(12 + 8 * (i / 4)), 3'b001, 3'b101);
      m[i] = 1'b0;
      step("brick_all", 0, 1, 0, m, 8'(i + 1));
      drive(3'b001, 8'd80, 8'd60, 3'b001, 3'b101);
      for (int k = 0; k < 3; k++) step("idle", 0, 0, 0, m, 8'(i + 1));
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clock);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain actual=%0d required=0 pending", sb.size());

    // Asynchronous reset mid-pulse clears cX without a clock edge
    drive(3'b000, 8'd80, 8'd60, 3'b001, 3'b001);
    @(negedge clock);
    drive(3'b001, 8'd159, 8'd60, 3'b001, 3'b001);
    @(posedge clock);
    #1;
    chk("async_pre", "cX", int'(cX), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst", "cX", int'(cX), 0);
    chk("async_rst", "brickMap", int'(brickMap), 16'hFFFF);
    @(negedge clock);
    reset = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
